cpu_state_ctrl: RTL and testbench

//   Instruction-cycle controller of the 8-bit RISC CPU. Sits directly downstream of the

---
 rtl/cpu_state_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_cpu_state_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_state_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_state_ctrl
//   Instruction-cycle controller of the 8-bit RISC CPU. Locks onto the fetch
//   phase of the clock generator, then walks eight states per instruction
//   (one per clk) and drives the datapath strobes. Decodes the 3-bit opcode
//   from the instruction register and stops the CPU on HLT.
//
//   Optional feature: define CPU_CTL_SYNC_CHECK_EN to enable the fetch-phase
//   consistency check (sync_err pulse and re-lock). Without it, fetch is only
//   used to find the first rising edge and sync_err is tied low.
//
// Parameters
//   NSTATES      states per instruction; equals the fetch period (8)
//
// Ports
//   clk          in   clock (clk1 of the clock generator)
//   rst          in   asynchronous, active-low reset
//   fetch        in   fetch phase (high for the first half of the instruction)
//   opcode[2:0]  in   IR[15:13]
//   zero         in   accumulator == 0
//   inc_pc       out  increment program counter
//   load_pc      out  load PC from IR address field
//   load_ir      out  latch data bus byte into IR
//   load_acc     out  latch ALU result into accumulator
//   rd           out  memory read strobe
//   wr           out  memory write strobe
//   datactl_ena  out  drive accumulator onto data bus
//   halt         out  CPU halted (sticky until reset)
//   sync_err     out  one-clk fetch-phase mismatch pulse
// ---------------------------------------------------------------------------
module cpu_state_ctrl #(
   parameter int NSTATES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fetch,
   input  logic [2:0] opcode,
   input  logic       zero,
   output logic       inc_pc,
   output logic       load_pc,
   output logic       load_ir,
   output logic       load_acc,
   output logic       rd,
   output logic       wr,
   output logic       datactl_ena,
   output logic       halt,
   output logic       sync_err
);

   localparam logic [2:0] OP_HLT = 3'b000;
   localparam logic [2:0] OP_SKZ = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_LDA = 3'b101;
   localparam logic [2:0] OP_STO = 3'b110;
   localparam logic [2:0] OP_JMP = 3'b111;

   localparam logic [3:0] LAST_STEP = 4'(NSTATES - 1);
   localparam logic [3:0] HALF_STEP = 4'(NSTATES / 2);

   // S0..S7 carry their step number so the sequencer can count through them.
   typedef enum logic [3:0] {
      S0   = 4'd0,
      S1   = 4'd1,
      S2   = 4'd2,
      S3   = 4'd3,
      S4   = 4'd4,
      S5   = 4'd5,
      S6   = 4'd6,
      S7   = 4'd7,
      IDLE = 4'd8,
      HALT = 4'd9
   } state_t;

   state_t     state_reg;
   state_t     state_next;
   logic       fetch_prev_reg;
   logic [3:0] step_next;
   logic       sync_bad;

   logic inc_pc_next, load_pc_next, load_ir_next, load_acc_next;
   logic rd_next, wr_next, datactl_ena_next, halt_next;

   logic is_alu;
   assign is_alu = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      step_next  = 4'd0;
      sync_bad   = 1'b0;
      case (state_reg)
         IDLE: begin
            // A rise is a 1 sample following a 0 sample; the prev register
            // resets to 1 so a fetch already high at release is ignored.
            if (fetch && !fetch_prev_reg)
               state_next = S0;
         end
         HALT: state_next = HALT;
         default: begin
            step_next  = (state_reg == LAST_STEP) ? 4'd0 : (state_reg + 4'd1);
            state_next = state_t'(step_next);
`ifdef CPU_CTL_SYNC_CHECK_EN
            // fetch, sampled at the edge entering a step, must be high for
            // the first half of the instruction and low for the second half.
            if (fetch != (step_next < HALF_STEP))
               sync_bad = 1'b1;
`endif
            if (sync_bad)
               state_next = IDLE;
            else if ((step_next == 4'd3) && (opcode == OP_HLT))
               state_next = HALT;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Strobe decode for the state being entered
   // ---------------------------------------------------------------
   always_comb begin
      inc_pc_next      = 1'b0;
      load_pc_next     = 1'b0;
      load_ir_next     = 1'b0;
      load_acc_next    = 1'b0;
      rd_next          = 1'b0;
      wr_next          = 1'b0;
      datactl_ena_next = 1'b0;
      halt_next        = 1'b0;
      case (state_next)
         S0, S1: begin
            rd_next      = 1'b1;
            load_ir_next = 1'b1;
            inc_pc_next  = 1'b1;
         end
         S3: inc_pc_next = 1'b1;
         S4: begin
            if (is_alu)
               rd_next = 1'b1;
            else if (opcode == OP_JMP)
               load_pc_next = 1'b1;
            else if (opcode == OP_STO)
               datactl_ena_next = 1'b1;
         end
         S5: begin
            if (is_alu) begin
               rd_next       = 1'b1;
               load_acc_next = 1'b1;
            end else if (opcode == OP_JMP) begin
               load_pc_next = 1'b1;
               inc_pc_next  = 1'b1;
            end else if (opcode == OP_STO) begin
               datactl_ena_next = 1'b1;
            end else if ((opcode == OP_SKZ) && zero) begin
               inc_pc_next = 1'b1;
            end
         end
         S6: begin
            if (opcode == OP_STO) begin
               wr_next          = 1'b1;
               datactl_ena_next = 1'b1;
            end
         end
         S7: begin
            if ((opcode == OP_SKZ) && zero)
               inc_pc_next = 1'b1;
         end
         HALT: halt_next = 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         fetch_prev_reg <= 1'b1;
         inc_pc         <= 1'b0;
         load_pc        <= 1'b0;
         load_ir        <= 1'b0;
         load_acc       <= 1'b0;
         rd             <= 1'b0;
         wr             <= 1'b0;
         datactl_ena    <= 1'b0;
         halt           <= 1'b0;
      end else begin
         state_reg      <= state_next;
         fetch_prev_reg <= fetch;
         inc_pc         <= inc_pc_next;
         load_pc        <= load_pc_next;
         load_ir        <= load_ir_next;
         load_acc       <= load_acc_next;
         rd             <= rd_next;
         wr             <= wr_next;
         datactl_ena    <= datactl_ena_next;
         halt           <= halt_next;
      end
   end

`ifdef CPU_CTL_SYNC_CHECK_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         sync_err <= 1'b0;
      else
         sync_err <= sync_bad;
   end
`else
   assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_state_ctrl.sv
module tb_cpu_state_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       fetch = 1'b0;
   logic [2:0] opcode = 3'b010;
   logic       zero = 1'b0;
   logic inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt, sync_err;

   int n_tests = 0;
   int n_fail  = 0;
   bit checking = 1'b0;

`ifdef CPU_CTL_SYNC_CHECK_EN
   localparam bit SYNC_ON = 1'b1;
`else
   localparam bit SYNC_ON = 1'b0;
`endif

   cpu_state_ctrl #(.NSTATES(8)) dut (
      .clk(clk), .rst(rst), .fetch(fetch), .opcode(opcode), .zero(zero),
      .inc_pc(inc_pc), .load_pc(load_pc), .load_ir(load_ir), .load_acc(load_acc),
      .rd(rd), .wr(wr), .datactl_ena(datactl_ena), .halt(halt), .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   // {inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt}
   logic [7:0] dut_vec;
   assign dut_vec = {inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt};

   // ---------------- reference model ----------------
   // phase: -1 waiting for lock, 0..7 instruction step, 8 halted
   int         m_phase = -1;
   bit         m_prev  = 1'b1;
   bit         m_serr  = 1'b0;
   logic [7:0] m_vec   = 8'h00;

   function automatic logic [7:0] expect_vec(int ph, logic [2:0] op, logic z);
      bit i = 0, lp = 0, li = 0, la = 0, r = 0, w = 0, d = 0, h = 0;
      bit alu = (op >= 3'd2) && (op <= 3'd5);
      bit skip = (op == 3'd1) && z;
      if (ph == 0 || ph == 1) begin r = 1; li = 1; i = 1; end
      if (ph == 3) i = 1;
      if (ph == 4) begin r = alu; lp = (op == 3'd7); d = (op == 3'd6); end
      if (ph == 5) begin
         r = alu; la = alu; lp = (op == 3'd7); i = (op == 3'd7) || skip; d = (op == 3'd6);
      end
      if (ph == 6) begin w = (op == 3'd6); d = (op == 3'd6); end
      if (ph == 7) i = skip;
      if (ph == 8) h = 1;
      return {i, lp, li, la, r, w, d, h};
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_phase = -1; m_prev = 1'b1; m_serr = 1'b0; m_vec = 8'h00;
      end else begin
         int nph;
         m_serr = 1'b0;
         if (m_phase == 8) nph = 8;
         else if (m_phase < 0) nph = (fetch && !m_prev) ? 0 : -1;
         else begin
            nph = (m_phase + 1) % 8;
            if (SYNC_ON && (fetch != (nph < 4))) begin m_serr = 1'b1; nph = -1; end
            else if (nph == 3 && opcode == 3'd0) nph = 8;
         end
         m_prev  = fetch;
         m_phase = nph;
         m_vec   = expect_vec(nph, opcode, zero);
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (checking) begin
         n_tests++;
         if (dut_vec !== m_vec || sync_err !== m_serr) begin
            n_fail++;
            $display("FAIL model t=%0t: {inc,ldpc,ldir,ldacc,rd,wr,dctl,halt}=%b sync_err=%b, required %b sync_err=%b",
                     $time, dut_vec, sync_err, m_vec, m_serr);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic pin(input string name, input logic [7:0] act, input logic [7:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %b, required %b", name, act, req);
      end
   endtask

   // drive inputs just after a falling edge, return at the next falling edge
   task automatic cycle(input logic f, input logic [2:0] op, input logic z, input logic r);
      #1;
      fetch = f; opcode = op; zero = z; rst = r;
      @(negedge clk);
   endtask

   logic [7:0] c_inc, c_pc, c_ir, c_acc, c_rd, c_wr, c_dc, c_halt, c_se;

   // One fetch period with opcode held; bit k of each capture = step k.
   task automatic run_instr(input logic [2:0] op, input logic z, input int glitch_k);
      for (int k = 0; k < 8; k++) begin
         logic f;
         f = (k < 4);
         if (k == glitch_k) f = ~f;
         cycle(f, op, z, 1'b1);
         c_inc[k] = inc_pc;  c_pc[k] = load_pc;  c_ir[k] = load_ir;
         c_acc[k] = load_acc; c_rd[k] = rd;      c_wr[k] = wr;
         c_dc[k]  = datactl_ena; c_halt[k] = halt; c_se[k] = sync_err;
      end
      $display("[TB] op=%b zero=%b glitch=%0d inc=%b rd=%b ir=%b acc=%b pc=%b wr=%b dctl=%b halt=%b serr=%b",
               op, z, glitch_k, c_inc, c_rd, c_ir, c_acc, c_pc, c_wr, c_dc, c_halt, c_se);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      @(negedge clk);
      checking = 1'b1;
      // 1: reset then idle with fetch low
      repeat (3) cycle(1'b0, 3'b010, 1'b0, 1'b0);
      repeat (5) cycle(1'b0, 3'b010, 1'b0, 1'b1);
      pin("idle_outputs", dut_vec, 8'b0000_0000);
      pin("idle_sync_err", {7'd0, sync_err}, 8'd0);

      // 2: ADD
      run_instr(3'b010, 1'b0, -1);
      pin("add_inc_pc",   c_inc, 8'b0000_1011);
      pin("add_rd",       c_rd,  8'b0011_0011);
      pin("add_load_ir",  c_ir,  8'b0000_0011);
      pin("add_load_acc", c_acc, 8'b0010_0000);
      // 3: STO (wraps from previous S7)
      run_instr(3'b110, 1'b0, -1);
      pin("sto_datactl", c_dc, 8'b0111_0000);
      pin("sto_wr",      c_wr, 8'b0100_0000);
      pin("sto_rd",      c_rd, 8'b0000_0011);
      // 4: SKZ
      run_instr(3'b001, 1'b1, -1);
      pin("skz_z1_inc_pc", c_inc, 8'b1010_1011);
      run_instr(3'b001, 1'b0, -1);
      pin("skz_z0_inc_pc", c_inc, 8'b0000_1011);
      // JMP
      run_instr(3'b111, 1'b0, -1);
      pin("jmp_load_pc", c_pc,  8'b0011_0000);
      pin("jmp_inc_pc",  c_inc, 8'b0010_1011);

      // 6: fetch forced low while in S1
      run_instr(3'b010, 1'b0, 2);
      pin("sync_err_pulse", c_se, SYNC_ON ? 8'b0001_0100 : 8'b0000_0000);
      pin("sync_load_ir",   c_ir, SYNC_ON ? 8'b0000_1011 : 8'b0000_0011);

      // 5: HLT
      run_instr(3'b000, 1'b0, -1);
      pin("hlt_halt",   c_halt, 8'b1111_1000);
      pin("hlt_inc_pc", c_inc,  8'b0000_0011);
      for (int n = 0; n < 20; n++)
         cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
      pin("halt_sticky", dut_vec, 8'b0000_0001);
      cycle(1'b0, 3'b010, 1'b0, 1'b0);
      pin("halt_reset", dut_vec, 8'b0000_0000);
      cycle(1'b0, 3'b010, 1'b0, 1'b1);

      // randomized instruction stream
      for (int n = 0; n < 200; n++) begin
         logic [2:0] op;
         op = 3'($urandom_range(0, 7));
         if (op == 3'd0 && $urandom_range(0, 3) != 0) op = 3'd2;
         for (int k = 0; k < 8; k++) begin
            logic f, r;
            f = (k < 4);
            if ($urandom_range(0, 39) == 0) f = ~f;
            r = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
            cycle(f, op, 1'($urandom_range(0, 1)), r);
         end
         $display("[TB] random instr %0d op=%b model_phase=%0d", n, op, m_phase);
         if (m_phase == 8) begin
            cycle(1'b0, op, 1'b0, 1'b0);
            cycle(1'b0, op, 1'b0, 1'b1);
         end
      end

      checking = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
